cla_pipe_addsub: RTL and testbench
==================================

Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 16-bit combinational CLA.
- WIDTH-bit operands are split into STAGES slices. Each slice is resolved by 4-bit lookahead groups in one registered stage, and the carry is passed stage to stage.
- Valid/ready handshake on both sides; one operation per cycle sustained throughput.
- Sits in the datapath wherever wide add/sub must close timing at the system clock.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4*STAGES.
- STAGES, 2, pipeline depth and slice count; 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle (combinational).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+ci; 1: A-B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB; for sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk). All stage valid bits, out_valid, sum, cout and ovf go to 0. in_ready is 1 the cycle after reset.
- Effective operands: B' = sub ? ~b : b; cin = sub ? 1 : ci.
- Accept: a beat transfers on clk when in_valid && in_ready.
- Pipeline:
  - Stage k (0..STAGES-1) computes bits [k*W/S +: W/S] from slice generate/propagate and the registered carry of stage k-1 (stage 0 uses cin).
  - Later operand slices are skewed forward through registers; completed sum slices are deskewed so that all of sum appears together.
  - Within a stage the carry is lookahead: group G/P per 4 bits, then a second lookahead level across groups. No ripple longer than one group.
- Latency: exactly STAGES cycles from accept to out_valid (out_ready held high).
- Stall: advance = !out_valid || out_ready. All stages hold when advance=0. in_ready = advance. Bubbles are not collapsed.
- Result hold: sum, cout and ovf are stable while out_valid && !out_ready.
- ovf = (A[msb] == B'[msb]) && (sum[msb] != A[msb]), computed in the last stage.
- Simultaneous accept and drain in the same cycle is allowed; there is no loss and no duplication.
- Ordering is strictly FIFO.
- Reset mid-operation: all in-flight beats are discarded; nothing is emitted after reset.
- No reset requirement on the data registers beyond the outputs listed above.

Optional Feature:
- Macro CLA_PIPE_SAT_EN.
- Defined:
  - Adds output port sat (1 bit).
  - On signed overflow, sum clamps to 0x7F..F (positive overflow) or 0x80..0 (negative overflow), and sat=1.
  - ovf still reports the unclamped condition. sat resets to 0.
- Undefined: port absent; sum wraps modulo 2^WIDTH.

Decomposition:
- Package cla_pkg:
  - GROUP_W=4.
  - Helper functions for group generate/propagate.
  - localparam-style constants SLICE_W=WIDTH/STAGES and GROUPS_PER_SLICE.
- Sub-module cla_group4:
  - Combinational 4-bit lookahead unit with inputs a, b, c_in.
  - Outputs s[3:0], gg, pg.
  - Instantiated GROUPS_PER_SLICE times per stage via generate.
- Top module contains the stage registers, skew/deskew and handshake.

Test Plan:
- Defaults, out_ready=1: a=0x0000FFFF, b=0x00000001, sub=0, ci=0 -> sum=0x00010000, cout=0, ovf=0; carry crosses the stage boundary; out_valid exactly 2 cycles after accept.
- a=0xFFFFFFFF, b=0x00000001, ci=0 -> sum=0x00000000, cout=1, ovf=0. Then a=0, b=0, ci=1 -> sum=0x00000001.
- sub=1, a=0x00000005, b=0x00000007, ci=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. a=0x80000000, b=1 -> sum=0x7FFFFFFF, ovf=1.
- a=0x7FFFFFFF, b=1 -> sum=0x80000000, ovf=1, cout=0. With CLA_PIPE_SAT_EN: sum=0x7FFFFFFF, sat=1.
- Backpressure:
  - Stimulus: 6 back-to-back beats (a=i, b=0x10*i, i=1..6); out_ready=0 for cycles 3-5.
  - in_ready drops on the cycle out_valid && !out_ready.
  - Outputs must be 0x11, 0x22, ..., 0x66 in order.
  - No gaps once out_ready=1; sum is held stable while stalled.
- Reset mid-operation: 2 beats in flight, rst_n=0 for 1 cycle -> out_valid=0 and sum=0 on the following cycle; no stale result ever appears; a new beat after reset returns correctly with latency 2.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and 4-bit group generate/propagate helpers for the pipelined CLA.
package cla_pkg;

    localparam int GROUP_W = 4;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic int groups_per_slice(input int width, input int stages);
        return width / (stages * GROUP_W);
    endfunction

    function automatic logic grp_gen(input logic [GROUP_W-1:0] g, input logic [GROUP_W-1:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic grp_prop(input logic [GROUP_W-1:0] p);
        return &p;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: per-bit sums plus group generate/propagate.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               c_in,
    output logic [GROUP_W-1:0] s,
    output logic               gg,
    output logic               pg
);

    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // All internal carries are flat sum-of-products of c_in; no ripple inside the group.
    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_in);

    assign s  = w_p ^ w_c;
    assign gg = grp_gen(w_g, w_p);
    assign pg = grp_prop(w_p);

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead add/sub, one WIDTH/STAGES slice resolved per registered stage.
// Optional CLA_PIPE_SAT_EN adds a sat output and clamps the sum on signed overflow.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef CLA_PIPE_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam int SLICE_W = slice_w(WIDTH, STAGES);
    localparam int GPS     = groups_per_slice(WIDTH, STAGES);

    logic             w_advance;
    logic             w_accept;
    logic [WIDTH-1:0] w_bp;
    logic             w_cin;

    logic [WIDTH-1:0] w_src_a   [STAGES];
    logic [WIDTH-1:0] w_src_b   [STAGES];
    logic [WIDTH-1:0] w_src_sum [STAGES];
    logic [WIDTH-1:0] w_nsum    [STAGES];
    logic [STAGES-1:0] w_src_c;
    logic [STAGES-1:0] w_ncarry;

    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_bp  [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_vld;
    logic             r_ovf;

    logic             w_ovf;
    logic [WIDTH-1:0] w_res;
`ifdef CLA_PIPE_SAT_EN
    logic             w_sat;
    logic             r_sat;
`endif

    assign out_valid = r_vld[STAGES-1];
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_accept  = in_valid && w_advance;
    assign w_bp      = sub ? ~b : b;
    assign w_cin     = sub | ci;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [GPS-1:0]     w_gg;
        logic [GPS-1:0]     w_pg;
        logic [GPS:0]       w_gc;
        logic [SLICE_W-1:0] w_s;
        logic               w_term;
        logic               w_cacc;

        if (k == 0) begin : g_head
            assign w_src_a[k]   = a;
            assign w_src_b[k]   = w_bp;
            assign w_src_c[k]   = w_cin;
            assign w_src_sum[k] = '0;
        end else begin : g_body
            assign w_src_a[k]   = r_a[k-1];
            assign w_src_b[k]   = r_bp[k-1];
            assign w_src_c[k]   = r_c[k-1];
            assign w_src_sum[k] = r_sum[k-1];
        end

        for (genvar g = 0; g < GPS; g++) begin : g_grp
            cla_group4 u_grp (
                .a    (w_src_a[k][k*SLICE_W + g*GROUP_W +: GROUP_W]),
                .b    (w_src_b[k][k*SLICE_W + g*GROUP_W +: GROUP_W]),
                .c_in (w_gc[g]),
                .s    (w_s[g*GROUP_W +: GROUP_W]),
                .gg   (w_gg[g]),
                .pg   (w_pg[g])
            );
        end

        // Second lookahead level: each group carry is an OR of products over group G/P.
        always_comb begin
            w_gc    = '0;
            w_term  = 1'b0;
            w_cacc  = 1'b0;
            w_gc[0] = w_src_c[k];
            for (int j = 1; j <= GPS; j++) begin
                w_term = w_src_c[k];
                for (int m = 0; m < j; m++) w_term = w_term & w_pg[m];
                w_cacc = w_term;
                for (int i = 0; i < j; i++) begin
                    w_term = w_gg[i];
                    for (int m = i + 1; m < j; m++) w_term = w_term & w_pg[m];
                    w_cacc = w_cacc | w_term;
                end
                w_gc[j] = w_cacc;
            end
        end

        assign w_nsum[k]   = w_src_sum[k] | (WIDTH'(w_s) << (k*SLICE_W));
        assign w_ncarry[k] = w_gc[GPS];
    end

    always_comb begin
        w_ovf = (w_src_a[STAGES-1][WIDTH-1] == w_src_b[STAGES-1][WIDTH-1])
             && (w_nsum[STAGES-1][WIDTH-1] != w_src_a[STAGES-1][WIDTH-1]);
        w_res = w_nsum[STAGES-1];
`ifdef CLA_PIPE_SAT_EN
        w_sat = 1'b0;
        // Operand sign picks the clamp direction: positive operands saturate to max.
        if (w_ovf) begin
            w_sat = 1'b1;
            w_res = {w_src_a[STAGES-1][WIDTH-1], {(WIDTH-1){~w_src_a[STAGES-1][WIDTH-1]}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld           <= '0;
            r_sum[STAGES-1] <= '0;
            r_c[STAGES-1]   <= 1'b0;
            r_ovf           <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
            r_sat           <= 1'b0;
`endif
        end else if (w_advance) begin
            r_vld[0] <= w_accept;
            for (int k = 1; k < STAGES; k++) r_vld[k] <= r_vld[k-1];
            for (int k = 0; k < STAGES - 1; k++) begin
                r_a[k]  <= w_src_a[k];
                r_bp[k] <= w_src_b[k];
            end
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= w_nsum[k];
                r_c[k]   <= w_ncarry[k];
            end
            r_sum[STAGES-1] <= w_res;
            r_ovf           <= w_ovf;
`ifdef CLA_PIPE_SAT_EN
            r_sat           <= w_sat;
`endif
        end
    end

    assign sum  = r_sum[STAGES-1];
    assign cout = r_c[STAGES-1];
    assign ovf  = r_ovf;
`ifdef CLA_PIPE_SAT_EN
    assign sat  = r_sat;
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub with an arithmetic reference model and FIFO scoreboard.
// Build with CLA_PIPE_SAT_EN defined to exercise the saturating variant.
module tb_cla_pipe_addsub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
`ifdef CLA_PIPE_SAT_EN
    logic             sat;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
`ifdef CLA_PIPE_SAT_EN
        ,
        .sat       (sat)
`endif
    );

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             sat;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] rx_sum[$];
    int               rx_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Signed/unsigned integer arithmetic on the effective operation, not on bit-level carries.
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mci, input logic msub);
        exp_t   e;
        longint sa, sb, res, ua, ub;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = longint'(ma);
        ub = longint'(mb);
        if (msub) begin
            res    = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            res    = sa + sb + longint'(mci);
            e.cout = ((ua + ub + longint'(mci)) > 64'sh FFFFFFFF);
        end
        e.ovf = (res > SMAX) || (res < SMIN);
        e.sum = res[WIDTH-1:0];
        e.sat = 1'b0;
`ifdef CLA_PIPE_SAT_EN
        if (e.ovf) begin
            e.sat = 1'b1;
            e.sum = (res > 0) ? 32'h7FFFFFFF : 32'h80000000;
        end
`endif
        return e;
    endfunction

    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout;
    logic             prev_ovf;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_sum", sum, prev_sum);
                chk("hold_flags", {cout, ovf}, {prev_cout, prev_ovf});
            end
            if (out_valid) begin
                chk("stale_out", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0 && out_ready) begin
                    e = exp_q.pop_front();
                    chk("model_sum", sum, e.sum);
                    chk("model_cout", cout, e.cout);
                    chk("model_ovf", ovf, e.ovf);
`ifdef CLA_PIPE_SAT_EN
                    chk("model_sat", sat, e.sat);
`endif
                    rx_sum.push_back(sum);
                    rx_cyc.push_back(cyc);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_cout  = cout;
            prev_ovf   = ovf;
            if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sub));
        end
    end

    task automatic run_one(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                           input logic tci, input logic tsub,
                           input logic [WIDTH-1:0] xs_wrap, input logic [WIDTH-1:0] xs_sat,
                           input logic xc, input logic xo);
        int               n;
        logic [WIDTH-1:0] xs;
        a        = ta;
        b        = tb_;
        ci       = tci;
        sub      = tsub;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("accept_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk("latency", n, STAGES);
        xs = xs_wrap;
`ifdef CLA_PIPE_SAT_EN
        if (xo) xs = xs_sat;
        chk("sat_lit", sat, xo);
`endif
        chk("sum_lit", sum, xs);
        chk("cout_lit", cout, xc);
        chk("ovf_lit", ovf, xo);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic saw_drop;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 32'h0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
`ifdef CLA_PIPE_SAT_EN
        chk("rst_sat", sat, 1'b0);
`endif
        @(posedge clk); #1;

        run_one(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 32'h00010000, 1'b0, 1'b0);
        run_one(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
        run_one(32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
        run_one(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_one(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1);
        run_one(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1);
        run_one(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 32'h00000002, 1'b1, 1'b0);
        run_one(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 32'h80000000, 1'b1, 1'b1);
        run_one(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0, 32'h22222222, 32'h22222222, 1'b0, 1'b0);

        // Backpressure: six back-to-back beats, downstream stalls in cycles 3..5.
        rx_sum.delete();
        rx_cyc.delete();
        saw_drop = 1'b0;
        begin
            int   sent;
            int   t;
            logic acc;
            sent = 0;
            t    = 0;
            while ((sent < 6 || rx_sum.size() < 6) && t < 40) begin
                in_valid  = (sent < 6);
                a         = WIDTH'(sent + 1);
                b         = WIDTH'(16 * (sent + 1));
                ci        = 1'b0;
                sub       = 1'b0;
                out_ready = !(t >= 3 && t <= 5);
                @(negedge clk);
                acc = in_valid && in_ready;
                if (!in_ready) saw_drop = 1'b1;
                @(posedge clk); #1;
                if (acc) sent++;
                t++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", rx_sum.size(), 6);
        chk("bp_in_ready_drop", saw_drop, 1'b1);
        if (rx_sum.size() == 6) begin
            for (int j = 0; j < 6; j++) chk("bp_order", rx_sum[j], WIDTH'(17 * (j + 1)));
            for (int j = 1; j < 5; j++) chk("bp_no_gap", rx_cyc[j+1] - rx_cyc[j], 1);
        end

        // Reset with two beats in flight.
        a         = 32'h0000000A;
        b         = 32'h00000005;
        ci        = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        a = 32'h00000100;
        b = 32'h00000001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_sum", sum, 32'h0);
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_stale", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        run_one(32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 32'h00000007, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
